// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: one partial-product step per cycle, WIDTH+2 cycles per result.
// Define MULT_SEQ_SIGNED_EN to compile in two's-complement support (sign-magnitude around the core).
module mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   dataOut
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplr_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CntW-1:0]    cnt_q;
  logic               done_q;
  logic [2*WIDTH-1:0] dout_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;

`ifdef MULT_SEQ_SIGNED_EN
  logic neg_q;
  logic neg_in;

  // Unary minus of the most negative value wraps to itself, which is the correct unsigned magnitude.
  always_comb begin
    mag_a  = (is_signed && dataA[WIDTH-1]) ? -dataA : dataA;
    mag_b  = (is_signed && dataB[WIDTH-1]) ? -dataB : dataB;
    neg_in = is_signed && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
    result = neg_q ? -acc_q : acc_q;
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;

  always_comb begin
    mag_a  = dataA;
    mag_b  = dataB;
    result = acc_q;
  end
`endif

  // The extra sum bit keeps the carry, which is shifted into the accumulator MSB.
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {sum, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dout_q  <= '0;
`ifdef MULT_SEQ_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mcand_q <= mag_a;
            mplr_q  <= mag_b;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef MULT_SEQ_SIGNED_EN
            neg_q   <= neg_in;
`endif
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q  <= acc_step;
          mplr_q <= mplr_q >> 1;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q <= StFinish;
          end
        end
        StFinish: begin
          dout_q  <= result;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign dataOut = dout_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq at WIDTH=32; expected products depend on MULT_SEQ_SIGNED_EN.
module tb_mult_seq;

  localparam int unsigned W = 32;

  logic           clk;
  logic           reset;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   dataA;
  logic [W-1:0]   dataB;
  logic           busy;
  logic           done;
  logic [2*W-1:0] dataOut;

  int checks   = 0;
  int failures = 0;

  mult_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dataA     (dataA),
    .dataB     (dataB),
    .busy      (busy),
    .done      (done),
    .dataOut   (dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    dataA     = a;
    dataB     = b;
    is_signed = s;
    start     = 1'b1;
  endtask

  // Returns with the bench sitting in the done cycle (or after a timeout).
  task automatic wait_done(input string tag, input logic [63:0] exp);
    int cyc;
    int busy_cnt;
    step();
    start    = 1'b0;
    cyc      = 1;
    busy_cnt = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      step();
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'd34);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, "_busy_low_at_done"}, 64'(busy), 64'd0);
    check({tag, "_product"}, dataOut, exp);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [63:0] exp);
    launch(a, b, s);
    wait_done(tag, exp);
    step();
    check({tag, "_done_pulse_width"}, 64'(done), 64'd0);
    check({tag, "_hold"}, dataOut, exp);
  endtask

  initial begin
    int ndone;
    reset     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dataA     = '0;
    dataB     = '0;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dataOut", dataOut, 64'd0);
    step();
    reset = 1'b1;
    step();

    run_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_op("unsigned_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b0, 64'h0000_0006_FFFF_FFEB);
    run_op("zero_a", 32'd0, 32'h1234_5678, 1'b0, 64'd0);
    run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
`ifdef MULT_SEQ_SIGNED_EN
    run_op("signed_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("signed_5xm4", 32'd5, 32'hFFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFEC);
    run_op("signed_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);
    run_op("signed_m1x2", 32'hFFFF_FFFF, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
`else
    run_op("ignored_sign_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 64'h0000_0006_FFFF_FFEB);
    run_op("ignored_sign_5xm4", 32'd5, 32'hFFFF_FFFC, 1'b1, 64'h0000_0004_FFFF_FFEC);
    run_op("ignored_sign_m1x2", 32'hFFFF_FFFF, 32'd2, 1'b1, 64'h0000_0001_FFFF_FFFE);
`endif

    // Second start (and operand/sign changes) during the run must not disturb it.
    launch(32'd5, 32'd6, 1'b0);
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    launch(32'd9, 32'd9, 1'b1);
    step();
    start     = 1'b0;
    dataA     = 32'hDEAD_BEEF;
    dataB     = 32'hFFFF_FFFF;
    ndone     = 0;
    for (int i = 0; i < 70; i++) begin
      if (done) begin
        ndone++;
        check("busy_start_product", dataOut, 64'd30);
      end
      step();
    end
    check("busy_start_single_done", 64'(ndone), 64'd1);
    check("busy_start_hold", dataOut, 64'd30);

    // Back-to-back: next start presented during the done cycle.
    launch(32'd4, 32'd5, 1'b0);
    wait_done("b2b_first", 64'd20);
    launch(32'd2, 32'd3, 1'b0);
    wait_done("b2b_second", 64'd6);
    step();

    // Reset in the middle of a run.
    launch(32'd1000, 32'd1000, 1'b0);
    step();
    start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("midrun_busy_before", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("midrun_busy_after", 64'(busy), 64'd0);
    check("midrun_dataOut", dataOut, 64'd0);
    check("midrun_done", 64'(done), 64'd0);
    step();
    step();
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      step();
    end
    check("midrun_no_done", 64'(ndone), 64'd0);
    check("midrun_dataOut_stays", dataOut, 64'd0);

    run_op("after_reset", 32'd3, 32'd4, 1'b0, 64'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
